// File: rtl/window_buffer_pkg.sv
// Shared constants and tap-index helpers for the CNN window buffer.
package window_buffer_pkg;

  localparam logic [1:0] SLIDE_NONE  = 2'd0;
  localparam logic [1:0] SLIDE_RIGHT = 2'd1;
  localparam logic [1:0] SLIDE_DOWN  = 2'd2;
  localparam logic [1:0] SLIDE_LEFT  = 2'd3;

  // Width of a tap index for a KSIZE x KSIZE kernel.
  function automatic int unsigned tap_idx_w(input int unsigned ksize);
    return (ksize * ksize > 1) ? $clog2(ksize * ksize) : 1;
  endfunction

  // LSB of tap t inside a packed window; tap 0 occupies the MSBs.
  function automatic int unsigned tap_lsb(input int unsigned t, input int unsigned taps,
                                          input int unsigned dw);
    return (taps - 1 - t) * dw;
  endfunction

endpackage

// File: rtl/wbf_slide_net.sv
// Combinational in-place slide of a packed KSIZE x KSIZE window (right, down or left).
module wbf_slide_net
  import window_buffer_pkg::*;
#(
  parameter int unsigned DW    = 128,
  parameter int unsigned KSIZE = 3,
  localparam int unsigned TAPS = KSIZE * KSIZE
) (
  input  logic [1:0]         mode,
  input  logic [TAPS*DW-1:0] din,
  output logic [TAPS*DW-1:0] dout
);

  // Vacated column/row keeps its old value: dout defaults to din.
  always_comb begin
    dout = din;
    for (int unsigned r = 0; r < KSIZE; r++) begin
      for (int unsigned c = 0; c < KSIZE; c++) begin
        case (mode)
          SLIDE_RIGHT: if (c < KSIZE - 1)
            dout[tap_lsb(r*KSIZE+c, TAPS, DW) +: DW] = din[tap_lsb(r*KSIZE+c+1, TAPS, DW) +: DW];
          SLIDE_DOWN: if (r < KSIZE - 1)
            dout[tap_lsb(r*KSIZE+c, TAPS, DW) +: DW] = din[tap_lsb((r+1)*KSIZE+c, TAPS, DW) +: DW];
          SLIDE_LEFT: if (c > 0)
            dout[tap_lsb(r*KSIZE+c, TAPS, DW) +: DW] = din[tap_lsb(r*KSIZE+c-1, TAPS, DW) +: DW];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/window_buffer_fifo.sv
// Window staging register plus DEPTH-entry window FIFO feeding the OPU.
// Optional debug row-select mux enabled by defining WINDOW_BUFFER_ROWSEL_EN.
module window_buffer_fifo
  import window_buffer_pkg::*;
#(
  parameter int unsigned DW    = 128,
  parameter int unsigned KSIZE = 3,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned TAPS = KSIZE * KSIZE,
  localparam int unsigned TW   = tap_idx_w(KSIZE),
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned WW   = TAPS * DW
) (
  input  logic          SYS_CLK,
  input  logic          SYS_RST,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [TW-1:0] wr_tap,
  input  logic          wr_zero,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  input  logic          slide_req,
  input  logic [1:0]    slide_mode,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [WW-1:0] rd_data,
  output logic [AW:0]   fill_cnt,
  output logic          tap_err
`ifdef WINDOW_BUFFER_ROWSEL_EN
  ,
  input  logic [$clog2(WW)-1:0] dbg_row_sel,
  output logic [DEPTH-1:0]      dbg_row_data
`endif
);

  logic [WW-1:0] stg_q, stg_d, stg_slid;
  logic [WW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          err_q;
  logic          empty, full, wr_acc, rd_acc, tap_ok;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wr_rdy = !full;
  assign rd_vld = !empty;
  assign wr_acc = wr_vld && !full;
  assign rd_acc = rd_vld && rd_rdy;
  assign tap_ok = (int'(wr_tap) < int'(TAPS));

  assign rd_data  = mem_q[rptr_q[AW-1:0]];
  assign fill_cnt = wptr_q - rptr_q;
  assign tap_err  = err_q;

  wbf_slide_net #(
    .DW    (DW),
    .KSIZE (KSIZE)
  ) u_slide (
    .mode (slide_req ? slide_mode : SLIDE_NONE),
    .din  (stg_q),
    .dout (stg_slid)
  );

  // Slide is never stalled; the tap write lands on top of the slid window.
  always_comb begin
    stg_d = stg_slid;
    if (wr_acc && tap_ok) begin
      stg_d[tap_lsb(int'(wr_tap), TAPS, DW) +: DW] = wr_zero ? '0 : wr_data;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      stg_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      stg_q <= stg_d;
      if (wr_acc && wr_last) begin
        mem_q[wptr_q[AW-1:0]] <= stg_d;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (rd_acc) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (wr_acc && !tap_ok) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef WINDOW_BUFFER_ROWSEL_EN
  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      dbg_row_data[e] = !SYS_RST && mem_q[e][dbg_row_sel];
    end
  end
`endif

endmodule

// File: tb/tb_window_buffer_fifo.sv
// Randomized scoreboard bench for window_buffer_fifo against a tap-array reference model.
module tb_window_buffer_fifo;
  import window_buffer_pkg::*;

  localparam int unsigned DW    = 128;
  localparam int unsigned KSIZE = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAPS  = KSIZE * KSIZE;
  localparam int unsigned TW    = 4;
  localparam int unsigned AW    = 3;
  localparam int unsigned WW    = TAPS * DW;

  typedef logic [DW-1:0] tap_t;

  logic          SYS_CLK = 1'b0;
  logic          SYS_RST = 1'b1;
  logic          wr_vld = 1'b0, wr_zero = 1'b0, wr_last = 1'b0, slide_req = 1'b0, rd_rdy = 1'b0;
  logic [TW-1:0] wr_tap = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    slide_mode = '0;
  logic          wr_rdy, rd_vld, tap_err;
  logic [WW-1:0] rd_data;
  logic [AW:0]   fill_cnt;
`ifdef WINDOW_BUFFER_ROWSEL_EN
  logic [$clog2(WW)-1:0] dbg_row_sel = '0;
  logic [DEPTH-1:0]      dbg_row_data;
`endif

  window_buffer_fifo #(.DW(DW), .KSIZE(KSIZE), .DEPTH(DEPTH)) dut (
    .SYS_CLK    (SYS_CLK),
    .SYS_RST    (SYS_RST),
    .wr_vld     (wr_vld),
    .wr_rdy     (wr_rdy),
    .wr_tap     (wr_tap),
    .wr_zero    (wr_zero),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .slide_req  (slide_req),
    .slide_mode (slide_mode),
    .rd_vld     (rd_vld),
    .rd_rdy     (rd_rdy),
    .rd_data    (rd_data),
    .fill_cnt   (fill_cnt),
    .tap_err    (tap_err)
`ifdef WINDOW_BUFFER_ROWSEL_EN
    ,
    .dbg_row_sel  (dbg_row_sel),
    .dbg_row_data (dbg_row_data)
`endif
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Reference model state
  tap_t          stg [TAPS];
  logic [WW-1:0] exp_q [$];
  logic [WW-1:0] pend_win;
  bit            pend_push, pend_err, exp_err, zero_exp = 1'b1, started, final_chk;
  int            checks, failures;

  function automatic logic [WW-1:0] pack_stg();
    logic [WW-1:0] w;
    for (int t = 0; t < int'(TAPS); t++) w[(int'(TAPS) - 1 - t) * int'(DW) +: DW] = stg[t];
    return w;
  endfunction

  function automatic void model_slide(input logic [1:0] mode);
    tap_t o [TAPS];
    o = stg;
    for (int r = 0; r < int'(KSIZE); r++) begin
      for (int c = 0; c < int'(KSIZE); c++) begin
        int t = r * int'(KSIZE) + c;
        if (mode == SLIDE_RIGHT && c < int'(KSIZE) - 1) stg[t] = o[t + 1];
        if (mode == SLIDE_LEFT && c > 0) stg[t] = o[t - 1];
        if (mode == SLIDE_DOWN && r < int'(KSIZE) - 1) stg[t] = o[t + int'(KSIZE)];
      end
    end
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void chk_win(input string nm, input logic [WW-1:0] act,
                                  input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int t = 0; t < int'(TAPS); t++) begin
        if (act[(int'(TAPS) - 1 - t) * int'(DW) +: DW] !== exp[(int'(TAPS) - 1 - t) * int'(DW) +: DW]) begin
          $display("FAIL %s: tap %0d got %h expected %h", nm, t,
                   act[(int'(TAPS) - 1 - t) * int'(DW) +: DW],
                   exp[(int'(TAPS) - 1 - t) * int'(DW) +: DW]);
          break;
        end
      end
    end
  endfunction

  // Monitor: status against model, pops against scoreboard, then retire pending stimulus effects
  initial begin
    forever begin
      @(negedge SYS_CLK);
      if (started) begin
        if (final_chk) chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("fill_cnt", 64'(fill_cnt), 64'(exp_q.size()));
        chk("rd_vld", 64'(rd_vld), 64'(exp_q.size() != 0));
        chk("wr_rdy", 64'(wr_rdy), 64'(exp_q.size() < int'(DEPTH)));
        chk("tap_err", 64'(tap_err), 64'(exp_err));
        if (zero_exp) chk_win("rd_data_zero", rd_data, '0);
        if (SYS_RST) begin
          exp_q.delete();
          exp_err   = 1'b0;
          pend_push = 1'b0;
          pend_err  = 1'b0;
          zero_exp  = 1'b1;
        end else begin
          if (rd_vld && rd_rdy && exp_q.size() > 0) chk_win("rd_data", rd_data, exp_q.pop_front());
          if (pend_err) exp_err = 1'b1;
          if (pend_push) begin
            exp_q.push_back(pend_win);
            zero_exp = 1'b0;
          end
          pend_push = 1'b0;
          pend_err  = 1'b0;
        end
      end
    end
  end

  function automatic tap_t rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one cycle; called at posedge+1, returns at the next posedge+1
  task automatic step(input bit v, input int tap, input bit z, input tap_t d, input bit last,
                      input bit sr, input logic [1:0] sm, input bit rr);
    bit acc;
    wr_vld = v; wr_tap = TW'(tap); wr_zero = z; wr_data = d; wr_last = last;
    slide_req = sr; slide_mode = sm; rd_rdy = rr;
    if (sr) model_slide(sm);
    acc = v && (exp_q.size() < int'(DEPTH));
    if (acc) begin
      if (tap < int'(TAPS)) stg[tap] = z ? '0 : d;
      else pend_err = 1'b1;
      if (last) begin
        pend_push = 1'b1;
        pend_win  = pack_stg();
      end
    end
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic wrt(input int tap, input tap_t d, input bit last);
    step(1'b1, tap, 1'b0, d, last, 1'b0, SLIDE_NONE, 1'b0);
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 0, 1'b0, '0, 1'b0, 1'b0, SLIDE_NONE, rr);
  endtask

  task automatic do_reset();
    wr_vld = 1'b0; wr_last = 1'b0; slide_req = 1'b0; rd_rdy = 1'b0;
    SYS_RST = 1'b1;
    for (int t = 0; t < int'(TAPS); t++) stg[t] = '0;
    @(posedge SYS_CLK);
    #1;
    SYS_RST = 1'b0;
  endtask

  initial begin
    for (int t = 0; t < int'(TAPS); t++) stg[t] = '0;
    repeat (2) @(posedge SYS_CLK);
    #1;
    SYS_RST = 1'b0;
    started = 1'b1;
    idle(1'b0);

    // Full window, taps 0x11..0x99
    for (int t = 0; t < 9; t++) wrt(t, tap_t'(32'h11 * (t + 1)), t == 8);
    // Slide right, refetch column 2
    step(1'b1, 2, 1'b0, tap_t'(8'hA0), 1'b0, 1'b1, SLIDE_RIGHT, 1'b0);
    wrt(5, tap_t'(8'hA1), 1'b0);
    wrt(8, tap_t'(8'hA2), 1'b1);
    // Fill to DEPTH, refused push, pop, then push succeeds
    for (int i = 0; i < 6; i++) wrt($urandom_range(0, 8), rnd(), 1'b1);
    wrt(0, rnd(), 1'b1);
    idle(1'b1);
    wrt(1, rnd(), 1'b1);
    // Full with pop and write together: write refused
    step(1'b1, 3, 1'b0, rnd(), 1'b1, 1'b0, SLIDE_NONE, 1'b1);
    for (int i = 0; i < 4 * int'(DEPTH) && exp_q.size() > 0; i++) idle(1'b1);
    // Empty with push and pop together: pop ignored
    step(1'b1, 4, 1'b0, rnd(), 1'b1, 1'b0, SLIDE_NONE, 1'b1);
    // Out-of-range tap with commit, then down slide with zero padding
    wrt(9, rnd(), 1'b1);
    step(1'b1, 6, 1'b1, rnd(), 1'b0, 1'b1, SLIDE_DOWN, 1'b0);
    step(1'b1, 7, 1'b1, rnd(), 1'b0, 1'b0, SLIDE_NONE, 1'b0);
    step(1'b1, 8, 1'b1, rnd(), 1'b1, 1'b0, SLIDE_NONE, 1'b0);
    idle(1'b0);
    // Reset mid-window
    for (int t = 0; t < 5; t++) wrt(t, rnd(), 1'b0);
    do_reset();
    idle(1'b0);
    for (int t = 0; t < 9; t++) wrt(t, rnd(), t == 8);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, ($urandom_range(0, 19) == 0) ? 9 : $urandom_range(0, 8),
                $urandom_range(0, 9) == 0, rnd(), $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
    end

    for (int i = 0; i < 4 * int'(DEPTH) && exp_q.size() > 0; i++) idle(1'b1);
    idle(1'b0);
    final_chk = 1'b1;
    @(negedge SYS_CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
